// File: rtl/risc_core_p.sv
// risc_core_p: multicycle 8-register core with pending-instruction buffer.
// Define RISC_CORE_ASR_EN to make shift code 11 an arithmetic right shift.
module risc_core_p #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic          load,
    input  logic [15:0]   in,
    output logic [DW-1:0] out,
    output logic          N,
    output logic          V,
    output logic          Z,
    output logic          w,
    output logic          pend,
    output logic          err
);
    typedef enum logic [2:0] {WAIT, DECODE, GET_A, GET_B, EXEC, WRITE} state_t;
    state_t state;
    logic [15:0] ir, pb;
    logic [DW-1:0] r [8];
    logic [DW-1:0] a, b, c, rm_v, asr_v, shv, diff, res;
    logic [2:0] opcode, rn, rd;
    logic [1:0] op, sh;
    logic mov_imm, mov_reg, cmp, legal;
    assign opcode  = ir[15:13];
    assign op      = ir[12:11];
    assign rn      = ir[10:8];
    assign rd      = ir[7:5];
    assign sh      = ir[4:3];
    assign mov_imm = opcode == 3'b110 && op == 2'b10;
    assign mov_reg = opcode == 3'b110 && op == 2'b00;
    assign cmp     = opcode == 3'b101 && op == 2'b01;
    assign legal   = opcode == 3'b101 || mov_imm || mov_reg;
    assign rm_v    = r[ir[2:0]];
`ifdef RISC_CORE_ASR_EN
    assign asr_v = {rm_v[DW-1], rm_v[DW-1:1]};
`else
    assign asr_v = rm_v >> 1;
`endif
    assign w = state == WAIT;
    always_comb begin
        shv  = sh == 2'b01 ? rm_v << 1 : sh == 2'b10 ? rm_v >> 1 : sh == 2'b11 ? asr_v : rm_v;
        diff = a - b;
        res  = mov_reg ? b : op == 2'b00 ? a + b : op == 2'b01 ? diff : op == 2'b10 ? a & b : ~b;
    end
    // Finishing with a buffered instruction skips WAIT and goes straight to DECODE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT;
            ir    <= '0;
            pb    <= '0;
            pend  <= 1'b0;
            a     <= '0;
            b     <= '0;
            c     <= '0;
            out   <= '0;
            N     <= 1'b0;
            V     <= 1'b0;
            Z     <= 1'b0;
            err   <= 1'b0;
            for (int i = 0; i < 8; i++) r[i] <= '0;
        end else begin
            if (state != WAIT && !pend && load) begin
                pb   <= in;
                pend <= 1'b1;
            end
            case (state)
                WAIT: begin
                    if (pend) begin
                        ir    <= pb;
                        pend  <= 1'b0;
                        state <= DECODE;
                    end else begin
                        if (load) ir <= in;
                        if (s) state <= DECODE;
                    end
                end
                DECODE: begin
                    c <= {{(DW-8){ir[7]}}, ir[7:0]};
                    if (!legal) begin
                        err   <= 1'b1;
                        state <= pend ? DECODE : WAIT;
                        if (pend) begin
                            ir   <= pb;
                            pend <= 1'b0;
                        end
                    end else begin
                        state <= mov_imm ? WRITE : mov_reg ? GET_B : GET_A;
                    end
                end
                GET_A: begin
                    a     <= r[rn];
                    state <= GET_B;
                end
                GET_B: begin
                    b     <= shv;
                    state <= EXEC;
                end
                EXEC: begin
                    c   <= res;
                    out <= res;
                    if (cmp) begin
                        N     <= diff[DW-1];
                        Z     <= diff == '0;
                        V     <= (a[DW-1] ^ b[DW-1]) & (diff[DW-1] ^ a[DW-1]);
                        state <= pend ? DECODE : WAIT;
                        if (pend) begin
                            ir   <= pb;
                            pend <= 1'b0;
                        end
                    end else begin
                        state <= WRITE;
                    end
                end
                WRITE: begin
                    r[mov_imm ? rn : rd] <= c;
                    out   <= c;
                    state <= pend ? DECODE : WAIT;
                    if (pend) begin
                        ir   <= pb;
                        pend <= 1'b0;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end
endmodule

// File: tb/tb_risc_core_p.sv
// tb_risc_core_p: directed scoreboard bench running DW=16 and DW=32 cores in lockstep.
module tb_risc_core_p;
    logic clk = 1'b0;
    logic reset, s, load;
    logic [15:0] in;
    logic [15:0] out16;
    logic [31:0] out32;
    logic n16, v16, z16, w16, p16, e16;
    logic n32, v32, z32, w32, p32, e32;
    int vectors = 0;
    int miscompares = 0;
    typedef struct {
        string       tag;
        logic [31:0] x16;
        logic [31:0] x32;
        int          busy;
        bit          has_out;
    } exp_t;
    exp_t sb[$];
`ifdef RISC_CORE_ASR_EN
    localparam logic [31:0] ASR16 = 32'h0000FFC0;
    localparam logic [31:0] ASR32 = 32'hFFFFFFC0;
`else
    localparam logic [31:0] ASR16 = 32'h00007FC0;
    localparam logic [31:0] ASR32 = 32'h7FFFFFC0;
`endif
    always #5 clk = ~clk;
    risc_core_p #(.DW(16)) u16 (.clk(clk), .reset(reset), .s(s), .load(load), .in(in), .out(out16),
        .N(n16), .V(v16), .Z(z16), .w(w16), .pend(p16), .err(e16));
    risc_core_p #(.DW(32)) u32 (.clk(clk), .reset(reset), .s(s), .load(load), .in(in), .out(out32),
        .N(n32), .V(v32), .Z(z32), .w(w32), .pend(p32), .err(e32));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [15:0] ins);
        @(negedge clk);
        in = ins;
        load = 1'b1;
        s = 1'b1;
        @(negedge clk);
        load = 1'b0;
        s = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!w16 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_done(input int n);
        exp_t e;
        e = sb.pop_front();
        chk({e.tag, "_busy"}, n, e.busy);
        chk({e.tag, "_w32"}, {31'b0, w32}, 32'd1);
        if (e.has_out) begin
            chk({e.tag, "_out16"}, {16'h0, out16}, e.x16);
            chk({e.tag, "_out32"}, out32, e.x32);
        end
    endtask

    task automatic run(input string tag, input logic [15:0] ins, input logic [31:0] x16,
                       input logic [31:0] x32, input int busy, input bit has_out);
        int n;
        sb.push_back('{tag, x16, x32, busy, has_out});
        start(ins);
        wait_idle(n);
        check_done(n);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        s = 1'b0;
        load = 1'b0;
        in = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_w", {31'b0, w16}, 32'd1);
        chk("rst_out", {16'h0, out16}, 32'd0);
        chk("rst_pend", {31'b0, p16}, 32'd0);
        chk("rst_err", {31'b0, e16}, 32'd0);
        chk("rst_nvz", {29'b0, n16, v16, z16}, 32'd0);

        run("mov_r0", 16'hD00A, 32'd10, 32'd10, 2, 1'b1);
        run("mov_r1", 16'hD103, 32'd3, 32'd3, 2, 1'b1);
        run("add", 16'hA188, 32'd23, 32'd23, 5, 1'b1);
        run("cmp_lt", 16'hA900, 32'd0, 32'd0, 4, 1'b0);
        chk("cmp_lt_nvz16", {29'b0, n16, v16, z16}, 32'b100);
        chk("cmp_lt_nvz32", {29'b0, n32, v32, z32}, 32'b100);
        run("cmp_eq", 16'hA901, 32'd0, 32'd0, 4, 1'b0);
        chk("cmp_eq_nvz16", {29'b0, n16, v16, z16}, 32'b001);
        chk("cmp_eq_nvz32", {29'b0, n32, v32, z32}, 32'b001);
        run("mov_m1", 16'hD0FF, 32'h0000FFFF, 32'hFFFFFFFF, 2, 1'b1);
        run("and", 16'hB041, 32'd3, 32'd3, 5, 1'b1);
        run("mvn", 16'hB861, 32'h0000FFFC, 32'hFFFFFFFC, 5, 1'b1);
        run("lsr", 16'hC0D1, 32'd1, 32'd1, 4, 1'b1);
        run("lsl", 16'hC0E8, 32'h0000FFFE, 32'hFFFFFFFE, 4, 1'b1);

        sb.push_back('{"pend", 32'd7, 32'd7, 7, 1'b1});
        start(16'hA188);
        in = 16'hD507;
        load = 1'b1;
        @(negedge clk);
        chk("pend_set", {31'b0, p16}, 32'd1);
        in = 16'hD509;
        @(negedge clk);
        load = 1'b0;
        wait_idle(n);
        check_done(n + 2);
        chk("pend_clr", {31'b0, p16}, 32'd0);

        run("undef", 16'hE000, 32'd7, 32'd7, 1, 1'b1);
        chk("undef_err", {31'b0, e16}, 32'd1);
        chk("undef_nvz", {29'b0, n16, v16, z16}, 32'b001);
        run("mov_neg", 16'hD080, 32'h0000FF80, 32'hFFFFFF80, 2, 1'b1);
        chk("err_sticky", {31'b0, e16}, 32'd1);
        run("asr", 16'hC038, ASR16, ASR32, 4, 1'b1);

        start(16'hA188);
        in = 16'hD507;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_w", {31'b0, w16}, 32'd1);
        chk("abort_pend", {31'b0, p16}, 32'd0);
        chk("abort_err", {31'b0, e16}, 32'd0);
        chk("abort_out", {16'h0, out16}, 32'd0);
        run("abort_rd", 16'hC0A4, 32'd0, 32'd0, 4, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
